mandel_core: RTL
================

MANDEL_CORE -- requirements
Module: mandel_core

Interface
REQ-001 Parameter X_MIN, default -16'sd10240, real part of column 0 (Q4.12; -2.5).
REQ-002 Parameter Y_MAX, default 16'sd5376, imaginary part of row 0 (Q4.12; 1.3125).
REQ-003 Parameter STEP, default 16'sd45, per-pixel increment (Q4.12; ~0.011).
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 calc  in  1  start pulse; sampled only in IDLE.
REQ-007 x  in  10  pixel column, captured with calc.
REQ-008 y  in  10  pixel row, captured with calc.
REQ-009 max_iter  in  12  iteration limit, captured with calc.
REQ-010 busy  out  1  high in MAP, ITER, DONE.
REQ-011 done  out  1  one-cycle result-valid strobe.
REQ-012 iter_count  out  12  escape count, valid while done is high, held until the next result.
REQ-013 colour  out  3  palette index, valid with iter_count.
REQ-014 px_x, px_y  out  10 each  captured x, y echoed with the result.

Function
REQ-015 FSM states SHALL be IDLE, MAP, ITER, DONE; transitions IDLE->MAP on calc, MAP->ITER always, ITER->DONE on escape or limit, ITER->ITER otherwise, DONE->IDLE always.
REQ-016 IDLE + calc SHALL latch x, y and max_iter into px_x, px_y and the internal limit; calc outside IDLE SHALL be ignored.
REQ-017 MAP SHALL compute c_re = X_MIN + x*STEP and c_im = Y_MAX - y*STEP, 16-bit signed Q4.12, wrapping on overflow, and clear z_re, z_im and n to 0.
REQ-018 Each ITER cycle SHALL form 32-bit products zr2 = z_re*z_re, zi2 = z_im*z_im, zri = z_re*z_im.
REQ-019 Escape SHALL be (zr2 + zi2) > 4.0, i.e. 33-bit unsigned sum > 2^26 (32'd67108864).
REQ-020 On escape, or n == limit, ITER SHALL go to DONE without updating z or n.
REQ-021 Otherwise z_re <= (zr2 - zi2)>>>12 + c_re, z_im <= (zri>>>11) + c_im, truncated to 16 bits; n <= n + 1.
REQ-022 Entering DONE SHALL register iter_count = n and colour = 3'b000 if n == limit, else 3'b111 if n[2:0] == 0, else n[2:0].
REQ-023 done SHALL be high exactly one cycle (state DONE); busy SHALL be high from the cycle after calc is sampled through DONE inclusive.
REQ-024 Latency: done SHALL rise n + 2 rising edges after the edge that sampled calc.
REQ-025 max_iter == 0 SHALL give iter_count 0, colour 3'b000, done 2 edges after calc.
REQ-026 x, y outside 320x240 SHALL be computed normally, with no range check.
REQ-027 calc held high SHALL start one computation per IDLE visit, i.e. back-to-back with one IDLE cycle between results.

Reset
REQ-028 reset SHALL take priority over all other inputs: state IDLE, busy 0, done 0, iter_count 0, colour 0, px_x 0, px_y 0, z and c registers 0.
REQ-029 reset mid-computation SHALL abort with no done pulse; a calc on the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-030 x=0, y=0, max_iter=100, calc pulse -> done 3 edges later, iter_count 1, colour 3'b001, px_x 0, px_y 0.
REQ-031 x=228, y=120 (c ~ 0.005-0.006i), max_iter=50 -> iter_count 50, colour 3'b000, done 52 edges after calc.
REQ-032 max_iter=0, any x/y -> done 2 edges after calc, iter_count 0, colour 3'b000.
REQ-033 Start x=228, y=120, max_iter=4000, second calc at edge 10 with x=5 -> second calc ignored, px_x stays 228, busy stays 1.
REQ-034 reset asserted at edge 20 of a max_iter=4000 run -> IDLE, all outputs 0, no done; next calc x=0, y=0 -> iter_count 1.
REQ-035 calc held high with x=0, y=0, max_iter=100 -> done pulses every 5 cycles, each with iter_count 1.

Source files
------------

// File: rtl/mandel_core.sv
// Mandelbrot escape-time pixel engine: done pulses n+2 clocks after calc is sampled.
// No backpressure; calc is only accepted in IDLE and ignored while busy.
module mandel_core #(
    parameter logic signed [15:0] X_MIN = -16'sd10240,
    parameter logic signed [15:0] Y_MAX = 16'sd5376,
    parameter logic signed [15:0] STEP  = 16'sd45
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        calc,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [11:0] max_iter,
    output logic        busy,
    output logic        done,
    output logic [11:0] iter_count,
    output logic [2:0]  colour,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic        [9:0]  px_x_q, px_x_d;
    logic        [9:0]  px_y_q, px_y_d;
    logic        [11:0] limit_q, limit_d;
    logic        [11:0] n_q, n_d;
    logic        [11:0] iter_q, iter_d;
    logic        [2:0]  colour_q, colour_d;
    logic signed [15:0] c_re_q, c_re_d;
    logic signed [15:0] c_im_q, c_im_d;
    logic signed [15:0] z_re_q, z_re_d;
    logic signed [15:0] z_im_q, z_im_d;

    logic        [15:0] x_step, y_step;
    logic signed [31:0] z_re_ext, z_im_ext;
    logic signed [31:0] zr2, zi2, zri;
    logic signed [31:0] re_full, im_full;
    logic        [32:0] mag2;
    logic               escape;
    logic               at_limit;

    // Column/row offsets only need the low 16 bits: the c mapping wraps mod 2^16.
    always_comb begin
        x_step   = 16'({6'd0, px_x_q} * STEP);
        y_step   = 16'({6'd0, px_y_q} * STEP);
        z_re_ext = 32'(z_re_q);
        z_im_ext = 32'(z_im_q);
        zr2      = z_re_ext * z_re_ext;
        zi2      = z_im_ext * z_im_ext;
        zri      = z_re_ext * z_im_ext;
        mag2     = {1'b0, zr2} + {1'b0, zi2};
        escape   = mag2 > 33'd67108864;
        at_limit = n_q == limit_q;
        re_full  = (zr2 - zi2) >>> 12;
        im_full  = zri >>> 11;
    end

    always_comb begin
        state_d  = state_q;
        px_x_d   = px_x_q;
        px_y_d   = px_y_q;
        limit_d  = limit_q;
        n_d      = n_q;
        iter_d   = iter_q;
        colour_d = colour_q;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        z_re_d   = z_re_q;
        z_im_d   = z_im_q;
        case (state_q)
            IDLE: begin
                if (calc) begin
                    px_x_d  = x;
                    px_y_d  = y;
                    limit_d = max_iter;
                    state_d = MAP;
                end
            end
            MAP: begin
                c_re_d  = X_MIN + $signed(x_step);
                c_im_d  = Y_MAX - $signed(y_step);
                z_re_d  = '0;
                z_im_d  = '0;
                n_d     = '0;
                state_d = ITER;
            end
            ITER: begin
                if (escape || at_limit) begin
                    iter_d = n_q;
                    if (at_limit) begin
                        colour_d = 3'b000;
                    end else if (n_q[2:0] == 3'b000) begin
                        colour_d = 3'b111;
                    end else begin
                        colour_d = n_q[2:0];
                    end
                    state_d = DONE;
                end else begin
                    z_re_d = re_full[15:0] + c_re_q;
                    z_im_d = im_full[15:0] + c_im_q;
                    n_d    = n_q + 12'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            px_x_q   <= '0;
            px_y_q   <= '0;
            limit_q  <= '0;
            n_q      <= '0;
            iter_q   <= '0;
            colour_q <= '0;
            c_re_q   <= '0;
            c_im_q   <= '0;
            z_re_q   <= '0;
            z_im_q   <= '0;
        end else begin
            state_q  <= state_d;
            px_x_q   <= px_x_d;
            px_y_q   <= px_y_d;
            limit_q  <= limit_d;
            n_q      <= n_d;
            iter_q   <= iter_d;
            colour_q <= colour_d;
            c_re_q   <= c_re_d;
            c_im_q   <= c_im_d;
            z_re_q   <= z_re_d;
            z_im_q   <= z_im_d;
        end
    end

    always_comb begin
        busy       = state_q != IDLE;
        done       = state_q == DONE;
        iter_count = iter_q;
        colour     = colour_q;
        px_x       = px_x_q;
        px_y       = px_y_q;
    end

endmodule
